// File: rtl/exc_pkg.sv
// Shared definitions for the CP0 exception request unit: cause codes,
// command FSM states and fixed widths.
package exc_pkg;

  localparam int EXC_W = 5;

  localparam logic [EXC_W-1:0] EXC_INT = 5'd0;
  localparam logic [EXC_W-1:0] EXC_SYS = 5'd8;
  localparam logic [EXC_W-1:0] EXC_BP  = 5'd9;
  localparam logic [EXC_W-1:0] EXC_TR  = 5'd13;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CMD    = 2'd1,
    ST_SETTLE = 2'd2
  } state_e;

endpackage

// File: rtl/irq_sync_edge.sv
// Per-line two-flop synchronizer followed by a rising-edge detector on the
// synchronized level.
module irq_sync_edge #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] rise_o
);

  logic [W-1:0] meta_q, sync_q, prev_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/exc_req_unit.sv
// Arbitrates sync exceptions, ERET and external interrupts into single-cycle
// CP0 commands, tracking handler nesting depth.
module exc_req_unit
  import exc_pkg::*;
#(
  parameter int N_IRQ    = 6,
  parameter int MAX_NEST = 3
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             syscall_i,
  input  logic             break_i,
  input  logic             trap_i,
  input  logic             eret_i,
  input  logic             sta_ie,
  input  logic [N_IRQ-1:0] sta_im,
  input  logic [N_IRQ-1:0] ext_irq,
  output logic             exception,
  output logic             eret,
  output logic [EXC_W-1:0] ex_type,
  output logic             stall,
  output logic             in_handler,
  output logic [N_IRQ-1:0] irq_pending,
  output logic             nest_ovf
);

  localparam int DW = $clog2(MAX_NEST + 1);
  localparam logic [DW-1:0] DEPTH_MAX = DW'(MAX_NEST);

  state_e           state_q, state_d;
  logic [EXC_W-1:0] type_q, type_d;
  logic             eret_q, eret_d;
  logic [DW-1:0]    depth_q, depth_d;
  logic             ovf_q, ovf_d;
  logic             hold_q, hold_d;
  logic [N_IRQ-1:0] pending_q, pending_d;

  logic [N_IRQ-1:0] irq_rise;
  logic [N_IRQ-1:0] irq_elig;
  logic [N_IRQ-1:0] irq_first;
  logic [N_IRQ-1:0] irq_grant;
  logic             sync_req;

  irq_sync_edge #(.W(N_IRQ)) u_sync (
    .clk    (clk),
    .rstn   (rstn),
    .d_i    (ext_irq),
    .rise_o (irq_rise)
  );

  assign sync_req  = syscall_i | break_i | trap_i;
  assign irq_elig  = pending_q & sta_im & {N_IRQ{sta_ie & (depth_q == '0)}};
  // Isolate the lowest set bit: lowest line index wins.
  assign irq_first = irq_elig & (~irq_elig + N_IRQ'(1));

  always_comb begin
    state_d   = state_q;
    type_d    = type_q;
    eret_d    = eret_q;
    depth_d   = depth_q;
    ovf_d     = ovf_q;
    hold_d    = hold_q;
    irq_grant = '0;
    case (state_q)
      ST_IDLE: begin
        if (sync_req) begin
          state_d = ST_CMD;
          eret_d  = 1'b0;
          type_d  = syscall_i ? EXC_SYS : (break_i ? EXC_BP : EXC_TR);
          if (depth_q == DEPTH_MAX) ovf_d = 1'b1;
          else                      depth_d = depth_q + DW'(1);
          if (eret_i) hold_d = 1'b1;
        end else if (hold_q || eret_i) begin
          state_d = ST_CMD;
          eret_d  = 1'b1;
          type_d  = EXC_INT;
          hold_d  = 1'b0;
          if (depth_q != '0) depth_d = depth_q - DW'(1);
        end else if (|irq_elig) begin
          state_d   = ST_CMD;
          eret_d    = 1'b0;
          type_d    = EXC_INT;
          irq_grant = irq_first;
          if (depth_q == DEPTH_MAX) ovf_d = 1'b1;
          else                      depth_d = depth_q + DW'(1);
        end
      end
      ST_CMD: begin
        state_d = ST_SETTLE;
        if (eret_i) hold_d = 1'b1;
      end
      ST_SETTLE: begin
        state_d = ST_IDLE;
        if (eret_i) hold_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign pending_d = (pending_q | irq_rise) & ~irq_grant;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      type_q    <= EXC_INT;
      eret_q    <= 1'b0;
      depth_q   <= '0;
      ovf_q     <= 1'b0;
      hold_q    <= 1'b0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      type_q    <= type_d;
      eret_q    <= eret_d;
      depth_q   <= depth_d;
      ovf_q     <= ovf_d;
      hold_q    <= hold_d;
      pending_q <= pending_d;
    end
  end

  // Command outputs decode from state so an asynchronous reset drops them at once.
  assign exception   = (state_q == ST_CMD);
  assign eret        = exception & eret_q;
  assign ex_type     = exception ? type_q : EXC_INT;
  assign stall       = (state_q == ST_CMD) || (state_q == ST_SETTLE);
  assign in_handler  = (depth_q != '0);
  assign irq_pending = pending_q;
  assign nest_ovf    = ovf_q;

endmodule

// File: tb/tb_exc_req_unit.sv
// Directed bench for exc_req_unit: reset, sync raise, interrupts, ERET
// hold, nesting overflow and asynchronous reset during a command.
module tb_exc_req_unit;

  logic       clk = 1'b0;
  logic       rstn;
  logic       syscall_i, break_i, trap_i, eret_i;
  logic       sta_ie;
  logic [5:0] sta_im;
  logic [5:0] ext_irq;
  logic       exception, eret, stall, in_handler, nest_ovf;
  logic [4:0] ex_type;
  logic [5:0] irq_pending;

  int n_tests = 0;
  int n_fail  = 0;

  exc_req_unit #(.N_IRQ(6), .MAX_NEST(3)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .syscall_i   (syscall_i),
    .break_i     (break_i),
    .trap_i      (trap_i),
    .eret_i      (eret_i),
    .sta_ie      (sta_ie),
    .sta_im      (sta_im),
    .ext_irq     (ext_irq),
    .exception   (exception),
    .eret        (eret),
    .ex_type     (ex_type),
    .stall       (stall),
    .in_handler  (in_handler),
    .irq_pending (irq_pending),
    .nest_ovf    (nest_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    rstn = 1'b0; syscall_i = 0; break_i = 0; trap_i = 0; eret_i = 0;
    sta_ie = 0; sta_im = '0; ext_irq = '0;
    #12;
    chk("rst_exception", {31'b0, exception}, 0);
    chk("rst_stall", {31'b0, stall}, 0);
    chk("rst_in_handler", {31'b0, in_handler}, 0);
    chk("rst_pending", {26'b0, irq_pending}, 0);
    chk("rst_ovf", {31'b0, nest_ovf}, 0);
    chk("rst_ex_type", {27'b0, ex_type}, 0);
    rstn = 1'b1;
    ticks(4);

    // Syscall: exception for one cycle, stall for two.
    syscall_i = 1; tick(); syscall_i = 0;
    chk("sys_exc", {31'b0, exception}, 1);
    chk("sys_type", {27'b0, ex_type}, 8);
    chk("sys_eret", {31'b0, eret}, 0);
    chk("sys_stall1", {31'b0, stall}, 1);
    chk("sys_inh", {31'b0, in_handler}, 1);
    tick();
    chk("sys_exc_off", {31'b0, exception}, 0);
    chk("sys_type_off", {27'b0, ex_type}, 0);
    chk("sys_stall2", {31'b0, stall}, 1);
    tick();
    chk("sys_stall_off", {31'b0, stall}, 0);
    $display("[TB] syscall raise checked");

    // Return to depth 0.
    eret_i = 1; tick(); eret_i = 0;
    chk("eret1_exc", {31'b0, exception}, 1);
    chk("eret1_eret", {31'b0, eret}, 1);
    chk("eret1_type", {27'b0, ex_type}, 0);
    ticks(2);
    chk("eret1_inh", {31'b0, in_handler}, 0);
    $display("[TB] eret return checked");

    // Interrupts on lines 0 and 2.
    sta_ie = 1; sta_im = 6'h3F; ext_irq = 6'b000101;
    ticks(3);
    chk("irq_pend_set", {26'b0, irq_pending}, 6'b000101);
    chk("irq_not_yet", {31'b0, exception}, 0);
    tick();
    chk("irq0_exc", {31'b0, exception}, 1);
    chk("irq0_type", {27'b0, ex_type}, 0);
    chk("irq0_eret", {31'b0, eret}, 0);
    chk("irq0_pend", {26'b0, irq_pending}, 6'b000100);
    ticks(4);
    chk("irq2_masked", {31'b0, exception}, 0);
    chk("irq2_still_pend", {26'b0, irq_pending}, 6'b000100);
    chk("irq_inh", {31'b0, in_handler}, 1);
    $display("[TB] interrupt line 0 taken, line 2 held");

    // ERET then line 2 three cycles later.
    eret_i = 1; tick(); eret_i = 0;
    chk("eret2_exc", {31'b0, exception}, 1);
    chk("eret2_eret", {31'b0, eret}, 1);
    ticks(2);
    chk("eret2_gap", {31'b0, exception}, 0);
    tick();
    chk("irq2_exc", {31'b0, exception}, 1);
    chk("irq2_eret", {31'b0, eret}, 0);
    chk("irq2_pend_clr", {26'b0, irq_pending}, 0);
    ticks(2);
    $display("[TB] line 2 raised after eret");

    ext_irq = '0;
    eret_i = 1; tick(); eret_i = 0;
    chk("eret3_exc", {31'b0, exception}, 1);
    ticks(2);
    chk("eret3_inh", {31'b0, in_handler}, 0);

    // Syscall and ERET together: Sys first, held ERET three cycles later.
    syscall_i = 1; eret_i = 1; tick(); syscall_i = 0; eret_i = 0;
    chk("both_sys_type", {27'b0, ex_type}, 8);
    chk("both_sys_eret", {31'b0, eret}, 0);
    tick();
    chk("both_gap1", {31'b0, exception}, 0);
    tick();
    chk("both_gap2", {31'b0, exception}, 0);
    tick();
    chk("both_eret_exc", {31'b0, exception}, 1);
    chk("both_eret_eret", {31'b0, eret}, 1);
    ticks(2);
    chk("both_inh", {31'b0, in_handler}, 0);
    $display("[TB] sys+eret ordering checked");

    // Four breaks, three cycles apart: overflow on the fourth.
    for (int b = 1; b <= 4; b++) begin
      break_i = 1; tick(); break_i = 0;
      chk($sformatf("brk%0d_type", b), {27'b0, ex_type}, 9);
      chk($sformatf("brk%0d_ovf", b), {31'b0, nest_ovf}, (b == 4) ? 1 : 0);
      ticks(2);
    end
    $display("[TB] nesting overflow checked");

    // Depth saturated at 3: three returns empty the handler stack.
    for (int r = 1; r <= 3; r++) begin
      eret_i = 1; tick(); eret_i = 0;
      chk($sformatf("unwind%0d_eret", r), {31'b0, eret}, 1);
      ticks(2);
      chk($sformatf("unwind%0d_inh", r), {31'b0, in_handler}, (r == 3) ? 0 : 1);
    end
    chk("ovf_sticky", {31'b0, nest_ovf}, 1);
    $display("[TB] unwind checked");

    // Asynchronous reset during CMD.
    trap_i = 1; tick(); trap_i = 0;
    chk("trap_type", {27'b0, ex_type}, 13);
    chk("trap_inh", {31'b0, in_handler}, 1);
    #1 rstn = 1'b0;
    #1;
    chk("arst_exc", {31'b0, exception}, 0);
    chk("arst_stall", {31'b0, stall}, 0);
    chk("arst_inh", {31'b0, in_handler}, 0);
    chk("arst_ovf", {31'b0, nest_ovf}, 0);
    $display("[TB] async reset during command checked");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
